// File: rtl/core_issue_ctrl_if.sv
// core_issue_ctrl_if
//   Groups the issue controller's interface to decode/execute/memory.
//   master: decode-side driver (instruction fields, load_done, branch resolve),
//           observes issue/stall/flush/MDU/scoreboard status.
//   slave : the issue controller itself.
//   Signals:
//     dec_valid, rs1_use, rs2_use, rd_use, rs1_addr, rs2_addr, rd_addr,
//     mem_op, mdu_op, mdu_control, is_branch       - decoded instruction
//     load_done, br_resolve, br_taken              - completion events
//     issue_valid, dec_stall, flush                - issue control
//     mdu_start, mdu_busy, mdu_done, mdu_rd        - MDU sequencing
//     pending                                      - register scoreboard
interface core_issue_ctrl_if;
  logic        dec_valid;
  logic        rs1_use;
  logic        rs2_use;
  logic        rd_use;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        mem_op;
  logic        mdu_op;
  logic        mdu_control;
  logic        is_branch;
  logic        load_done;
  logic        br_resolve;
  logic        br_taken;
  logic        issue_valid;
  logic        dec_stall;
  logic        flush;
  logic        mdu_start;
  logic        mdu_busy;
  logic        mdu_done;
  logic [4:0]  mdu_rd;
  logic [31:0] pending;

  modport master (
    output dec_valid, rs1_use, rs2_use, rd_use, rs1_addr, rs2_addr, rd_addr,
           mem_op, mdu_op, mdu_control, is_branch, load_done, br_resolve, br_taken,
    input  issue_valid, dec_stall, flush, mdu_start, mdu_busy, mdu_done, mdu_rd, pending
  );

  modport slave (
    input  dec_valid, rs1_use, rs2_use, rd_use, rs1_addr, rs2_addr, rd_addr,
           mem_op, mdu_op, mdu_control, is_branch, load_done, br_resolve, br_taken,
    output issue_valid, dec_stall, flush, mdu_start, mdu_busy, mdu_done, mdu_rd, pending
  );
endinterface

// File: rtl/core_issue_ctrl.sv
// core_issue_ctrl
//   Issue/hazard controller between decode and execute. Keeps a scoreboard of
//   registers awaiting a load or MDU writeback, sequences the multi-cycle MDU,
//   tracks one outstanding memory op and one unresolved branch, and reports
//   taken-branch flushes.
//   Ports:
//     clk - core clock
//     rst - synchronous active-low reset
//     bus - core_issue_ctrl_if.slave (decode inputs, issue/MDU/scoreboard outputs)
module core_issue_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  core_issue_ctrl_if.slave  bus
);

  typedef enum logic { MDU_IDLE, MDU_BUSY } mdu_state_e;
  typedef enum logic { BR_RUN, BR_WAIT } br_state_e;

  // Counter is loaded with LAT-1 so that done lands exactly LAT cycles after issue.
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

  mdu_state_e  mdu_state_q, mdu_state_d;
  br_state_e   br_state_q, br_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]  mdu_rd_q, mdu_rd_d;
  logic        mdu_wr_q, mdu_wr_d;     // in-flight MDU op actually writes mdu_rd
  logic        load_busy_q, load_busy_d;
  logic [4:0]  load_rd_q, load_rd_d;   // 0 for stores, so clearing it is harmless
  logic [31:0] pending_q, pending_d;

  logic mdu_busy_w, mdu_done_w, brw_w, flush_w;
  logic raw_w, waw_w, struct_w, issue_w;

  // Hazard detection from registered state and current decode inputs
  always_comb begin
    mdu_busy_w = (mdu_state_q == MDU_BUSY);
    mdu_done_w = mdu_busy_w && (cnt_q == '0);
    brw_w      = (br_state_q == BR_WAIT);
    flush_w    = brw_w & bus.br_resolve & bus.br_taken;
    raw_w      = (bus.rs1_use & pending_q[bus.rs1_addr]) |
                 (bus.rs2_use & pending_q[bus.rs2_addr]);
    waw_w      = bus.rd_use & pending_q[bus.rd_addr];
    // MDU stays busy through its done cycle, which gives the one-cycle
    // structural stall for a back-to-back MDU op.
    struct_w   = (bus.mdu_op & mdu_busy_w) | (bus.mem_op & load_busy_q);
    issue_w    = bus.dec_valid & ~raw_w & ~waw_w & ~struct_w & ~brw_w & ~flush_w;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      mdu_state_q <= MDU_IDLE;
      br_state_q  <= BR_RUN;
      cnt_q       <= '0;
      mdu_rd_q    <= '0;
      mdu_wr_q    <= 1'b0;
      load_busy_q <= 1'b0;
      load_rd_q   <= '0;
      pending_q   <= '0;
    end else begin
      mdu_state_q <= mdu_state_d;
      br_state_q  <= br_state_d;
      cnt_q       <= cnt_d;
      mdu_rd_q    <= mdu_rd_d;
      mdu_wr_q    <= mdu_wr_d;
      load_busy_q <= load_busy_d;
      load_rd_q   <= load_rd_d;
      pending_q   <= pending_d;
    end
  end

  // Next-state logic
  always_comb begin
    mdu_state_d = mdu_state_q;
    br_state_d  = br_state_q;
    cnt_d       = cnt_q;
    mdu_rd_d    = mdu_rd_q;
    mdu_wr_d    = mdu_wr_q;
    load_busy_d = load_busy_q;
    load_rd_d   = load_rd_q;
    pending_d   = pending_q;

    // Clears first; sets below target a different register because waw
    // blocks any issue that would write a still-pending destination.
    if (load_busy_q && bus.load_done) begin
      load_busy_d          = 1'b0;
      pending_d[load_rd_q] = 1'b0;
    end

    unique case (mdu_state_q)
      MDU_IDLE: begin
        if (issue_w && bus.mdu_op) begin
          mdu_state_d = MDU_BUSY;
          cnt_d       = bus.mdu_control ? DIV_INIT : MUL_INIT;
          mdu_rd_d    = bus.rd_addr;
          mdu_wr_d    = bus.rd_use;
        end
      end
      MDU_BUSY: begin
        if (cnt_q == '0) begin
          mdu_state_d = MDU_IDLE;
          if (mdu_wr_q) pending_d[mdu_rd_q] = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: mdu_state_d = MDU_IDLE;
    endcase

    unique case (br_state_q)
      BR_RUN:  if (issue_w && bus.is_branch) br_state_d = BR_WAIT;
      BR_WAIT: if (bus.br_resolve)           br_state_d = BR_RUN;
      default: br_state_d = BR_RUN;
    endcase

    if (issue_w && bus.mem_op) begin
      load_busy_d = 1'b1;
      load_rd_d   = bus.rd_use ? bus.rd_addr : 5'd0;
    end
    if (issue_w && bus.rd_use && (bus.mem_op || bus.mdu_op) && (bus.rd_addr != 5'd0))
      pending_d[bus.rd_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Outputs, forced to 0 while reset is held
  logic        issue_valid_o, dec_stall_o, flush_o, mdu_start_o, mdu_busy_o, mdu_done_o;
  logic [4:0]  mdu_rd_o;
  logic [31:0] pending_o;

  always_comb begin
    issue_valid_o = rst & issue_w;
    dec_stall_o   = rst & bus.dec_valid & ~issue_w;
    flush_o       = rst & flush_w;
    mdu_start_o   = rst & issue_w & bus.mdu_op;
    mdu_busy_o    = rst & mdu_busy_w;
    mdu_done_o    = rst & mdu_done_w;
    mdu_rd_o      = rst ? mdu_rd_q  : 5'd0;
    pending_o     = rst ? pending_q : 32'd0;
  end

  assign bus.issue_valid = issue_valid_o;
  assign bus.dec_stall   = dec_stall_o;
  assign bus.flush       = flush_o;
  assign bus.mdu_start   = mdu_start_o;
  assign bus.mdu_busy    = mdu_busy_o;
  assign bus.mdu_done    = mdu_done_o;
  assign bus.mdu_rd      = mdu_rd_o;
  assign bus.pending     = pending_o;

endmodule

// File: tb/tb_core_issue_ctrl.sv
// tb_core_issue_ctrl
//   Directed scenarios plus a randomized run checked against a cycle-numbered
//   reference model (set of pending registers, absolute MDU completion cycle).
module tb_core_issue_ctrl;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  core_issue_ctrl_if bus ();

  core_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  bit         m_pend [32];
  bit         m_load_out;
  logic [4:0] m_load_rd;
  bit         m_load_wr;
  bit         m_mdu_act;
  int         m_done_cyc;
  logic [4:0] m_mdu_rd;
  bit         m_mdu_wr;
  bit         m_brw;
  int         cyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.dec_valid = 0; bus.rs1_use = 0; bus.rs2_use = 0; bus.rd_use = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0; bus.rd_addr = 0;
    bus.mem_op = 0; bus.mdu_op = 0; bus.mdu_control = 0; bus.is_branch = 0;
    bus.load_done = 0; bus.br_resolve = 0; bus.br_taken = 0;
  endtask

  task automatic present(input logic v, input logic mem, input logic mdu, input logic ctl,
                         input logic br, input logic r1u, input logic [4:0] r1,
                         input logic r2u, input logic [4:0] r2,
                         input logic rdu, input logic [4:0] rd);
    bus.dec_valid = v; bus.mem_op = mem; bus.mdu_op = mdu; bus.mdu_control = ctl;
    bus.is_branch = br; bus.rs1_use = r1u; bus.rs1_addr = r1;
    bus.rs2_use = r2u; bus.rs2_addr = r2; bus.rd_use = rdu; bus.rd_addr = rd;
  endtask

  task automatic test_reset();
    rst = 0;
    present(1, 0, 1, 1, 0, 1, 5'd3, 1, 5'd4, 1, 5'd5);
    bus.load_done = 1; bus.br_resolve = 1; bus.br_taken = 1;
    tick(); tick(); #2;
    n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_issue got=%b exp=0", bus.issue_valid); end
    n_checks++; if (bus.dec_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", bus.dec_stall); end
    n_checks++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
    n_checks++; if (bus.mdu_start !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_start got=%b exp=0", bus.mdu_start); end
    n_checks++; if (bus.mdu_busy !== 1'b0 || bus.mdu_done !== 1'b0) begin n_fail++; $display("FAIL reset_mdu got busy=%b done=%b exp 0/0", bus.mdu_busy, bus.mdu_done); end
    n_checks++; if (bus.pending !== 32'd0 || bus.mdu_rd !== 5'd0) begin n_fail++; $display("FAIL reset_state got pending=%h mdu_rd=%0d exp 0/0", bus.pending, bus.mdu_rd); end
    tick(); rst = 1; clr_in(); #2;
    n_checks++; if (bus.pending !== 32'd0 || bus.mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release got pending=%h busy=%b exp 0/0", bus.pending, bus.mdu_busy); end
  endtask

  task automatic test_load_use();
    tick(); present(1, 1, 0, 0, 0, 1, 5'd2, 0, 5'd0, 1, 5'd5); #2;
    n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL lu_lw_issue got=%b exp=1", bus.issue_valid); end
    for (int c = 1; c <= 5; c++) begin
      tick(); present(1, 0, 0, 0, 0, 1, 5'd5, 1, 5'd1, 1, 5'd7); bus.load_done = (c == 4); #2;
      n_checks++; if (bus.issue_valid !== (c == 5)) begin n_fail++; $display("FAIL lu_issue c=%0d got=%b exp=%b", c, bus.issue_valid, (c == 5)); end
      n_checks++; if (bus.dec_stall !== (c < 5)) begin n_fail++; $display("FAIL lu_stall c=%0d got=%b exp=%b", c, bus.dec_stall, (c < 5)); end
      n_checks++; if (bus.pending[5] !== (c < 5)) begin n_fail++; $display("FAIL lu_pending5 c=%0d got=%b exp=%b", c, bus.pending[5], (c < 5)); end
    end
    tick(); clr_in();
  endtask

  task automatic test_mul_chain();
    tick(); present(1, 0, 1, 0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd8); #2;
    n_checks++; if (bus.issue_valid !== 1'b1 || bus.mdu_start !== 1'b1) begin n_fail++; $display("FAIL mul_start got issue=%b start=%b exp 1/1", bus.issue_valid, bus.mdu_start); end
    tick(); present(1, 0, 0, 0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd10); #2;
    n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL mul_indep_issue got=%b exp=1", bus.issue_valid); end
    n_checks++; if (bus.mdu_busy !== 1'b1 || bus.mdu_rd !== 5'd8) begin n_fail++; $display("FAIL mul_busy got busy=%b rd=%0d exp 1/8", bus.mdu_busy, bus.mdu_rd); end
    for (int c = 2; c <= 4; c++) begin
      tick(); present(1, 0, 0, 0, 0, 1, 5'd8, 1, 5'd8, 1, 5'd9); #2;
      n_checks++; if (bus.mdu_done !== (c == 3)) begin n_fail++; $display("FAIL mul_done c=%0d got=%b exp=%b", c, bus.mdu_done, (c == 3)); end
      n_checks++; if (bus.issue_valid !== (c == 4)) begin n_fail++; $display("FAIL mul_dep_issue c=%0d got=%b exp=%b", c, bus.issue_valid, (c == 4)); end
      n_checks++; if (bus.pending[8] !== (c < 4)) begin n_fail++; $display("FAIL mul_pending8 c=%0d got=%b exp=%b", c, bus.pending[8], (c < 4)); end
    end
    tick(); clr_in();
  endtask

  task automatic test_struct_mdu();
    tick(); present(1, 0, 1, 1, 0, 1, 5'd3, 1, 5'd4, 1, 5'd11); #2;
    n_checks++; if (bus.mdu_start !== 1'b1) begin n_fail++; $display("FAIL st_div_start got=%b exp=1", bus.mdu_start); end
    for (int c = 1; c <= DIV_LAT + 1; c++) begin
      tick(); present(1, 0, 1, 0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd12); #2;
      n_checks++; if (bus.issue_valid !== (c == DIV_LAT + 1) || bus.mdu_start !== (c == DIV_LAT + 1)) begin
        n_fail++; $display("FAIL st_mul_issue c=%0d got issue=%b start=%b exp=%b", c, bus.issue_valid, bus.mdu_start, (c == DIV_LAT + 1)); end
      n_checks++; if (bus.mdu_done !== (c == DIV_LAT)) begin n_fail++; $display("FAIL st_div_done c=%0d got=%b exp=%b", c, bus.mdu_done, (c == DIV_LAT)); end
    end
    for (int c = DIV_LAT + 2; c <= DIV_LAT + 1 + MUL_LAT; c++) begin
      tick(); clr_in(); #2;
      n_checks++; if (bus.mdu_done !== (c == DIV_LAT + 1 + MUL_LAT)) begin n_fail++; $display("FAIL st_mul_done c=%0d got=%b exp=%b", c, bus.mdu_done, (c == DIV_LAT + 1 + MUL_LAT)); end
    end
    tick(); clr_in();
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      tick(); present(1, 0, 0, 0, 1, 1, 5'd1, 1, 5'd2, 0, 5'd0); #2;
      n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL br_issue taken=%0d got=%b exp=1", t, bus.issue_valid); end
      for (int c = 1; c <= 3; c++) begin
        tick(); present(1, 0, 0, 0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd3);
        bus.br_resolve = (c == 2); bus.br_taken = (t == 1); #2;
        n_checks++; if (bus.flush !== (t == 1 && c == 2)) begin n_fail++; $display("FAIL br_flush taken=%0d c=%0d got=%b exp=%b", t, c, bus.flush, (t == 1 && c == 2)); end
        n_checks++; if (bus.issue_valid !== (c == 3)) begin n_fail++; $display("FAIL br_next_issue taken=%0d c=%0d got=%b exp=%b", t, c, bus.issue_valid, (c == 3)); end
      end
      tick(); clr_in();
    end
  endtask

  task automatic test_x0_waw();
    tick(); present(1, 1, 0, 0, 0, 1, 5'd1, 0, 5'd0, 1, 5'd0); #2;
    n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL x0_issue got=%b exp=1", bus.issue_valid); end
    tick(); clr_in(); bus.load_done = 1; #2;
    n_checks++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL x0_pending got=%h exp=0", bus.pending); end
    tick(); clr_in(); present(1, 1, 0, 0, 0, 1, 5'd1, 0, 5'd0, 1, 5'd5); #2;
    n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL waw_lw_issue got=%b exp=1", bus.issue_valid); end
    for (int c = 1; c <= 4; c++) begin
      tick(); present(1, 0, 0, 0, 0, 1, 5'd1, 1, 5'd2, 1, 5'd5); bus.load_done = (c == 3); #2;
      n_checks++; if (bus.dec_stall !== (c < 4) || bus.issue_valid !== (c == 4)) begin
        n_fail++; $display("FAIL waw_stall c=%0d got stall=%b issue=%b exp=%b/%b", c, bus.dec_stall, bus.issue_valid, (c < 4), (c == 4)); end
    end
    tick(); present(1, 1, 0, 0, 0, 1, 5'd1, 0, 5'd0, 1, 5'd6); bus.load_done = 0; #2;
    n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL sw_lw_issue got=%b exp=1", bus.issue_valid); end
    for (int c = 1; c <= 3; c++) begin
      tick(); present(1, 1, 0, 0, 0, 1, 5'd1, 1, 5'd2, 0, 5'd0); bus.load_done = (c == 2); #2;
      n_checks++; if (bus.issue_valid !== (c == 3)) begin n_fail++; $display("FAIL sw_issue c=%0d got=%b exp=%b", c, bus.issue_valid, (c == 3)); end
    end
    tick(); clr_in(); bus.load_done = 1; #2;
    n_checks++; if (bus.pending !== 32'd0) begin n_fail++; $display("FAIL sw_pending got=%h exp=0", bus.pending); end
    tick(); clr_in();
  endtask

  task automatic test_reset_mid_div();
    bit done_seen;
    tick(); present(1, 0, 1, 1, 0, 1, 5'd1, 1, 5'd2, 1, 5'd5); #2;
    n_checks++; if (bus.mdu_start !== 1'b1) begin n_fail++; $display("FAIL rdiv_start got=%b exp=1", bus.mdu_start); end
    for (int c = 1; c <= 9; c++) begin tick(); clr_in(); end
    tick(); clr_in(); rst = 0; #2;
    n_checks++; if (bus.pending !== 32'd0 || bus.mdu_busy !== 1'b0) begin n_fail++; $display("FAIL rdiv_in_reset got pending=%h busy=%b exp 0/0", bus.pending, bus.mdu_busy); end
    tick(); rst = 1; present(1, 0, 0, 0, 0, 1, 5'd5, 1, 5'd1, 1, 5'd6); #2;
    n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL rdiv_add_issue got=%b exp=1", bus.issue_valid); end
    n_checks++; if (bus.pending !== 32'd0 || bus.mdu_busy !== 1'b0) begin n_fail++; $display("FAIL rdiv_after got pending=%h busy=%b exp 0/0", bus.pending, bus.mdu_busy); end
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick(); clr_in(); #2;
      if (bus.mdu_done === 1'b1) done_seen = 1;
    end
    n_checks++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL rdiv_late_done got=%b exp=0", done_seen); end
  endtask

  task automatic test_random();
    bit held, v, mem, mdu, ctl, br, r1u, r2u, rdu;
    logic [4:0] r1, r2, rd;
    bit exp_done, exp_flush, exp_issue, raw, waw, st;
    logic [31:0] exp_pend;
    int kind;
    // reset both DUT and model
    tick(); clr_in(); rst = 0;
    tick(); rst = 1;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_load_out = 0; m_load_rd = 0; m_load_wr = 0; m_mdu_act = 0; m_done_cyc = 0;
    m_mdu_rd = 0; m_mdu_wr = 0; m_brw = 0; cyc = 0; held = 0;
    #2;
    for (int n = 0; n < 3000; n++) begin
      if (n != 0) tick();
      if (!held) begin
        v = ($urandom_range(0, 3) != 0);
        kind = $urandom_range(0, 4);
        r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        mem = 0; mdu = 0; ctl = 0; br = 0;
        r1u = $urandom_range(0, 1); r2u = $urandom_range(0, 1); rdu = $urandom_range(0, 1);
        case (kind)
          1: begin mem = 1; rdu = 1; r1u = 1; r2u = 0; end
          2: begin mem = 1; rdu = 0; r1u = 1; r2u = 1; end
          3: begin mdu = 1; ctl = ($urandom_range(0, 3) == 0); rdu = ($urandom_range(0, 7) != 0); end
          4: begin br = 1; end
          default: ;
        endcase
        present(v, mem, mdu, ctl, br, r1u, r1, r2u, r2, rdu, rd);
        held = v;
      end
      bus.load_done  = m_load_out ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      bus.br_resolve = m_brw ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.br_taken   = $urandom_range(0, 1);
      #2;
      exp_done  = m_mdu_act && (cyc == m_done_cyc);
      raw       = (r1u && m_pend[r1]) || (r2u && m_pend[r2]);
      waw       = rdu && m_pend[rd];
      st        = (mdu && m_mdu_act) || (mem && m_load_out);
      exp_flush = m_brw && bus.br_resolve && bus.br_taken;
      exp_issue = v && !raw && !waw && !st && !m_brw;
      for (int i = 0; i < 32; i++) exp_pend[i] = m_pend[i];
      n_checks++; if (bus.issue_valid !== exp_issue) begin n_fail++; $display("FAIL rand_issue cyc=%0d got=%b exp=%b", cyc, bus.issue_valid, exp_issue); end
      n_checks++; if (bus.dec_stall !== (v && !exp_issue)) begin n_fail++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, bus.dec_stall, (v && !exp_issue)); end
      n_checks++; if (bus.flush !== exp_flush) begin n_fail++; $display("FAIL rand_flush cyc=%0d got=%b exp=%b", cyc, bus.flush, exp_flush); end
      n_checks++; if (bus.mdu_start !== (exp_issue && mdu)) begin n_fail++; $display("FAIL rand_start cyc=%0d got=%b exp=%b", cyc, bus.mdu_start, (exp_issue && mdu)); end
      n_checks++; if (bus.mdu_done !== exp_done || bus.mdu_busy !== m_mdu_act) begin
        n_fail++; $display("FAIL rand_mdu cyc=%0d got done=%b busy=%b exp %b/%b", cyc, bus.mdu_done, bus.mdu_busy, exp_done, m_mdu_act); end
      n_checks++; if (bus.mdu_rd !== m_mdu_rd) begin n_fail++; $display("FAIL rand_mdu_rd cyc=%0d got=%0d exp=%0d", cyc, bus.mdu_rd, m_mdu_rd); end
      n_checks++; if (bus.pending !== exp_pend) begin n_fail++; $display("FAIL rand_pending cyc=%0d got=%h exp=%h", cyc, bus.pending, exp_pend); end
      // advance the model to the next cycle
      if (m_load_out && bus.load_done) begin
        m_load_out = 0;
        if (m_load_wr) m_pend[m_load_rd] = 0;
      end
      if (exp_done) begin
        m_mdu_act = 0;
        if (m_mdu_wr) m_pend[m_mdu_rd] = 0;
      end
      if (m_brw && bus.br_resolve) m_brw = 0;
      if (exp_issue) begin
        if (mem) begin m_load_out = 1; m_load_rd = rd; m_load_wr = rdu; end
        if (mdu) begin
          m_mdu_act = 1; m_done_cyc = cyc + (ctl ? DIV_LAT : MUL_LAT);
          m_mdu_rd = rd; m_mdu_wr = rdu;
        end
        if ((mem || mdu) && rdu && rd != 0) m_pend[rd] = 1;
        if (br) m_brw = 1;
      end
      if (exp_issue || exp_flush) held = 0;
      cyc++;
    end
    tick(); clr_in();
  endtask

  initial begin
    rst = 0;
    clr_in();
    test_reset();
    test_load_use();
    test_mul_chain();
    test_struct_mdu();
    test_branch();
    test_x0_waw();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
